calc_op_sequencer: RTL and testbench

Sequencer for the calculator datapath. It turns debounced push-button levels into single-shot operation requests and loads or updates a signed accumulator from the switch operand. Arithmetic is handed to a shared multi-cycle ALU through a start/done handshake, with a timeout and error handling. It sits between the debounced button/switch inputs and the ALU, and drives the accumulator to the LED and 7-segment formatting logic.

---
 rtl/calc_op_sequencer.sv | 109 ++++++++++
 tb/tb_calc_op_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: turns button edges into load/ALU requests on a signed accumulator,
// with a start/done ALU handshake, a WAIT timeout and a sticky error state.
module calc_op_sequencer #(
    parameter int BITS    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_c,
    input  logic            btn_u,
    input  logic            btn_d,
    input  logic            btn_l,
    input  logic            btn_r,
    input  logic [BITS-1:0] sw,
    output logic            alu_start,
    output logic [1:0]      alu_op,
    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_b,
    input  logic            alu_done,
    input  logic [BITS-1:0] alu_result,
    input  logic            alu_ovf,
    output logic [BITS-1:0] acc,
    output logic            result_valid,
    output logic            busy,
    output logic            err,
    output logic [1:0]      err_code
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, ERR} state_t;

    state_t          state, state_n;
    logic [4:0]      btn, prev, press;
    logic [1:0]      op_sel, code_n;
    logic            op_hit;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] res;

    // bit 0 is the load button so the lowest index carries the highest priority
    assign btn       = {btn_r, btn_l, btn_d, btn_u, btn_c};
    assign press     = btn & ~prev;
    assign op_hit    = |press[4:1];
    assign op_sel    = press[1] ? 2'd0 : press[2] ? 2'd1 : press[3] ? 2'd2 : 2'd3;
    assign alu_start = state == ISSUE;
    assign busy      = state == ISSUE || state == WAIT || state == WRITE;
    assign err       = state == ERR;

    always_comb begin
        state_n = state;
        code_n  = err_code;
        case (state)
            IDLE: begin
                if (!press[0] && op_hit) begin
                    state_n = (op_sel == 2'd3 && sw == '0) ? ERR : ISSUE;
                    code_n  = (op_sel == 2'd3 && sw == '0) ? 2'b01 : err_code;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                // a completion in the expiry cycle still counts as success
                if (alu_done) begin
                    state_n = alu_ovf ? ERR : WRITE;
                    code_n  = alu_ovf ? 2'b10 : err_code;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n = ERR;
                    code_n  = 2'b11;
                end
            end
            WRITE: state_n = IDLE;
            ERR: begin
                state_n = press[0] ? IDLE : ERR;
                code_n  = press[0] ? 2'b00 : err_code;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            prev         <= '0;
            cnt          <= '0;
            res          <= '0;
            acc          <= '0;
            alu_op       <= 2'b00;
            alu_a        <= '0;
            alu_b        <= '0;
            err_code     <= 2'b00;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            prev         <= btn;
            err_code     <= code_n;
            result_valid <= (state == IDLE && press[0]) || state == WRITE;
            cnt          <= (state == ISSUE) ? '0 : (state == WAIT) ? cnt + 1'b1 : cnt;
            if (state == IDLE && press[0])
                acc <= sw;
            if (state == WRITE)
                acc <= res;
            if (state == IDLE && !press[0] && op_hit) begin
                alu_op <= op_sel;
                alu_a  <= acc;
                alu_b  <= sw;
            end
            if (state == WAIT && alu_done && !alu_ovf)
                res <= alu_result;
        end
    end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed stimulus with a queue scoreboard for result, ALU request
// and error events, checked by an independent monitor.
module tb_calc_op_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  b = '0;
    logic [15:0] sw = '0;
    logic        alu_start, alu_done, alu_ovf, result_valid, busy, err;
    logic [1:0]  alu_op, err_code;
    logic [15:0] alu_a, alu_b, alu_result, acc;

    logic        m_done = 1'b0, m_ovf = 1'b0, inj_done = 1'b0, mute = 1'b0, ovf_v = 1'b0;
    logic [15:0] m_res = '0, inj_res = '0, res_v = '0;
    int          dly = 3;

    int vecs = 0, errs = 0, n_start = 0, exp_start = 0, n;
    logic        err_q = 1'b0;
    logic [63:0] q_rv[$], q_st[$], q_er[$];

    assign alu_done   = m_done | inj_done;
    assign alu_result = inj_done ? inj_res : m_res;
    assign alu_ovf    = m_ovf;

    calc_op_sequencer #(.BITS(16), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .btn_c(b[0]), .btn_u(b[1]), .btn_d(b[2]), .btn_l(b[3]), .btn_r(b[4]),
        .sw(sw),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
        .acc(acc), .result_valid(result_valid), .busy(busy),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ALU model: answers each request after dly cycles unless muted
    initial begin
        forever begin
            @(negedge clk);
            if (alu_start && !mute) begin
                repeat (dly) @(negedge clk);
                m_done = 1'b1;
                m_res  = res_v;
                m_ovf  = ovf_v;
                @(negedge clk);
                m_done = 1'b0;
                m_ovf  = 1'b0;
            end
        end
    end

    // monitor: every observable event pops and checks its expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (result_valid) begin
                if (q_rv.size() == 0) chk("unexpected_result_valid", {48'd0, acc}, 64'hDEAD);
                else chk("acc_on_result_valid", {48'd0, acc}, q_rv.pop_front());
            end
            if (alu_start) begin
                n_start++;
                if (q_st.size() == 0) chk("unexpected_alu_start", {30'd0, alu_op, alu_a, alu_b}, 64'hDEAD);
                else chk("alu_request", {30'd0, alu_op, alu_a, alu_b}, q_st.pop_front());
            end
            if (err && !err_q) begin
                if (q_er.size() == 0) chk("unexpected_err", {62'd0, err_code}, 64'hDEAD);
                else chk("err_code_on_err", {62'd0, err_code}, q_er.pop_front());
            end
        end
        err_q = err;
    end

    task automatic press(input int idx, input logic [15:0] v);
        sw = v;
        b[idx] = 1'b1;
        @(negedge clk);
        b[idx] = 1'b0;
    endtask

    task automatic wait_rv(output int cnt);
        cnt = 0;
        while (!result_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!result_valid) chk("result_valid_timeout", 0, 1);
    endtask

    task automatic wait_err(output int cnt);
        cnt = 0;
        while (!err && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!err) chk("err_wait_timeout", 0, 1);
    endtask

    task automatic op(input int idx, input logic [15:0] v, input logic [1:0] o,
                      input logic [15:0] a, input logic [15:0] r);
        q_st.push_back({30'd0, o, a, v});
        q_rv.push_back({48'd0, r});
        exp_start++;
        res_v = r;
        press(idx, v);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_acc", {48'd0, acc}, 0);
        chk("rst_flags", {59'd0, alu_start, result_valid, busy, err, err_code[0]}, 0);
        chk("rst_alu_regs", {30'd0, alu_op, alu_a, alu_b}, 0);
        chk("rst_err_code", {62'd0, err_code}, 0);
        #2 rst = 1'b0;
        @(negedge clk);

        q_rv.push_back(64'd5);
        press(0, 16'd5);
        wait_rv(n);
        chk("load_latency", n, 0);
        @(negedge clk);

        dly = 3;
        op(1, 16'd7, 2'd0, 16'd5, 16'd12);
        chk("busy_in_issue", {63'd0, busy}, 1);
        wait_rv(n);
        chk("add_latency", n, 5);
        @(negedge clk);
        chk("acc_after_add", {48'd0, acc}, 12);

        q_rv.push_back(64'hFFFD);
        press(0, 16'hFFFD);
        repeat (2) @(negedge clk);
        op(2, 16'd4, 2'd1, 16'hFFFD, 16'hFFF9);
        wait_rv(n);
        @(negedge clk);
        op(3, 16'd2, 2'd2, 16'hFFF9, 16'hFFF2);
        wait_rv(n);
        @(negedge clk);
        chk("acc_after_mul", {48'd0, acc}, 64'hFFF2);

        q_rv.push_back(64'd9);
        press(0, 16'd9);
        repeat (2) @(negedge clk);
        q_er.push_back(64'd1);
        press(4, 16'd0);
        chk("divzero_err_next_cycle", {63'd0, err}, 1);
        chk("divzero_code", {62'd0, err_code}, 1);
        press(1, 16'd3);
        repeat (3) @(negedge clk);
        chk("err_ignores_u", {60'd0, err, busy, err_code}, 64'b1001);
        press(0, 16'd77);
        chk("err_cleared", {60'd0, err, busy, err_code}, 0);
        chk("acc_kept_after_clear", {48'd0, acc}, 9);

        mute = 1'b1;
        q_st.push_back({30'd0, 2'd0, 16'd9, 16'd1});
        exp_start++;
        q_er.push_back(64'd3);
        press(1, 16'd1);
        wait_err(n);
        chk("timeout_latency", n, 65);
        chk("timeout_acc", {48'd0, acc}, 9);
        press(0, 16'd0);
        mute = 1'b0;

        ovf_v = 1'b1;
        q_st.push_back({30'd0, 2'd2, 16'd9, 16'd3});
        exp_start++;
        q_er.push_back(64'd2);
        press(3, 16'd3);
        wait_err(n);
        chk("ovf_latency", n, 4);
        chk("ovf_acc_unchanged", {48'd0, acc}, 9);
        press(0, 16'd0);
        ovf_v = 1'b0;
        chk("ovf_cleared", {63'd0, err}, 0);

        dly = 5;
        q_st.push_back({30'd0, 2'd0, 16'd9, 16'd2});
        q_rv.push_back(64'd11);
        exp_start++;
        res_v = 16'd11;
        sw = 16'd2;
        b[1] = 1'b1;
        b[2] = 1'b1;
        @(negedge clk);
        b = '0;
        repeat (2) @(negedge clk);
        press(2, 16'd6);
        wait_rv(n);
        repeat (5) @(negedge clk);
        chk("starts_after_busy_press", n_start, exp_start);

        dly = 2;
        q_st.push_back({30'd0, 2'd2, 16'd11, 16'd2});
        q_rv.push_back(64'd22);
        exp_start++;
        res_v = 16'd22;
        sw = 16'd2;
        b[3] = 1'b1;
        repeat (100) @(negedge clk);
        b[3] = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_button_one_request", n_start, exp_start);
        chk("acc_after_held", {48'd0, acc}, 22);

        mute = 1'b1;
        q_st.push_back({30'd0, 2'd0, 16'd22, 16'd1});
        exp_start++;
        press(1, 16'd1);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_acc", {48'd0, acc}, 0);
        chk("async_rst_flags", {59'd0, alu_start, result_valid, busy, err, err_code[0]}, 0);
        chk("async_rst_alu_regs", {30'd0, alu_op, alu_a, alu_b}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        inj_res = 16'd99;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_done_ignored", {48'd0, acc}, 0);
        chk("idle_after_rst", {62'd0, busy, alu_start}, 0);
        chk("total_starts", n_start, exp_start);
        chk("rv_queue_drained", q_rv.size(), 0);
        chk("start_queue_drained", q_st.size(), 0);
        chk("err_queue_drained", q_er.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
